// File: rtl/vector_sweep_if.sv
// Bundle between the sweep checker and the unit under test plus its status outputs.
// The checker uses the master modport; the unit/host side uses the slave modport.
interface vector_sweep_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] stim;
    logic         dut_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic [N-1:0] first_fail;
    logic [1:0]   state_dbg;

    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, first_fail, state_dbg
    );

    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, first_fail, state_dbg
    );
endinterface

// File: rtl/vector_sweep_checker.sv
// Exhaustive stimulus sweep over 0..2^N-1 with truth-table response checking.
// Optional first-failure capture is built when VECTOR_SWEEP_FIRST_FAIL_EN is defined.
module vector_sweep_checker #(
    parameter int               N      = 4,
    parameter int               HOLD   = 50,
    parameter logic [2**N-1:0]  EXPECT = 16'h6996
) (
    input  logic               clk,
    input  logic               rst,
    vector_sweep_if.master     bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    state_t        state_q, state_n;
    logic [N-1:0]  stim_q, stim_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [N:0]    err_q, err_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          pass_q, pass_n;
    logic          mismatch;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
    logic [N-1:0]  ff_q, ff_n;
`endif

    assign mismatch = (bus.dut_out != EXPECT[stim_q]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
            ff_q    <= '0;
`endif
        end else begin
            state_q <= state_n;
            stim_q  <= stim_n;
            hold_q  <= hold_n;
            err_q   <= err_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
            ff_q    <= ff_n;
`endif
        end
    end

    always_comb begin
        state_n = state_q;
        stim_n  = stim_q;
        hold_n  = hold_q;
        err_n   = err_q;
        busy_n  = busy_q;
        done_n  = done_q;
        pass_n  = pass_q;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
        ff_n    = ff_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    stim_n  = '0;
                    hold_n  = '0;
                    err_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
                    ff_n    = '0;
`endif
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        err_n = err_q + 1'b1;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
                        if (err_q == '0) ff_n = stim_q;
`endif
                    end
                    // pass must include the compare made on this final sample edge
                    if (stim_q == {N{1'b1}}) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end else begin
                        stim_n = stim_q + 1'b1;
                        hold_n = '0;
                    end
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.stim      = stim_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.state_dbg = state_q;
`ifdef VECTOR_SWEEP_FIRST_FAIL_EN
    assign bus.first_fail = ff_q;
`else
    assign bus.first_fail = '0;
`endif
endmodule

// File: tb/tb_vector_sweep_checker.sv
// Bench for vector_sweep_checker: N=4/HOLD=3 parity instance plus an N=2/HOLD=1 AND2 instance,
// with random truth-table units checked against a behavioural sweep model.
module tb_vector_sweep_checker;
  localparam int N = 4;
  localparam int HOLD = 3;
  localparam logic [15:0] EXP = 16'h6996;
  localparam int SWEEP = HOLD * 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_sweep_if #(.N(N)) bus ();
  vector_sweep_if #(.N(2)) bus2 ();

  vector_sweep_checker #(.N(N), .HOLD(HOLD), .EXPECT(EXP)) dut (.clk(clk), .rst(rst), .bus(bus));
  vector_sweep_checker #(.N(2), .HOLD(1), .EXPECT(4'b1000)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [15:0] rand_tt = 16'h0;
  logic [15:0] exp_tt = EXP;
  logic and_mode = 1'b1;
  int run_cyc;

  // cycle index within the running sweep, derived only from busy
  always @(posedge clk or posedge rst) begin
    if (rst) run_cyc <= 0;
    else     run_cyc <= bus.busy ? run_cyc + 1 : 0;
  end

  // unit models: 0 parity, 1 stuck-at-0, 2 parity inverted at 12, 3 random table, 4 parity valid only on last hold cycle
  function automatic logic unit_fn(int m, logic [3:0] v, int phase, logic [15:0] tt);
    case (m)
      0: return ^v;
      1: return 1'b0;
      2: return (^v) ^ (v == 4'd12);
      3: return tt[v];
      default: return (^v) ^ (phase != HOLD - 1);
    endcase
  endfunction

  always_comb bus.dut_out = unit_fn(mode, bus.stim, run_cyc % HOLD, rand_tt);
  always_comb bus2.dut_out = and_mode ? (&bus2.stim) : (|bus2.stim);

  function automatic void model_sweep(int m, logic [15:0] tt, output int err, output int ff);
    err = 0;
    ff = 0;
    for (int v = 0; v < 16; v++) begin
      if (unit_fn(m, 4'(v), HOLD - 1, tt) != exp_tt[v]) begin
        if (err == 0) ff = v;
        err++;
      end
    end
  endfunction

  task automatic do_sweep(input int restart_at, output int busy_cyc, output int stim_bad, output bit timed_out);
    busy_cyc = 0;
    stim_bad = 0;
    timed_out = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 400; t++) begin
      bus.start = 1'b0;
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.busy) begin
        if (bus.stim !== 4'(busy_cyc / HOLD)) stim_bad++;
        busy_cyc++;
        if (busy_cyc == restart_at) bus.start = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_sweep(input string name, input int m, input int restart_at);
    int busy_cyc, stim_bad, exp_err, exp_ff;
    bit timed_out;
    do_sweep(restart_at, busy_cyc, stim_bad, timed_out);
    model_sweep(m, rand_tt, exp_err, exp_ff);
`ifndef VECTOR_SWEEP_FIRST_FAIL_EN
    exp_ff = 0;
`endif
    checks++;
    if (timed_out) begin errors++; $display("FAIL %s timeout: done never rose", name); end
    checks++;
    if (busy_cyc != SWEEP) begin errors++; $display("FAIL %s busy_len got %0d want %0d", name, busy_cyc, SWEEP); end
    checks++;
    if (stim_bad != 0) begin errors++; $display("FAIL %s stim_seq got %0d bad cycles want 0", name, stim_bad); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, bus.busy); end
    checks++;
    if (bus.err_count !== 5'(exp_err)) begin errors++; $display("FAIL %s err_count got %0d want %0d", name, bus.err_count, exp_err); end
    checks++;
    if (bus.pass !== (exp_err == 0)) begin errors++; $display("FAIL %s pass got %b want %b", name, bus.pass, exp_err == 0); end
    checks++;
    if (bus.first_fail !== 4'(exp_ff)) begin errors++; $display("FAIL %s first_fail got %0d want %0d", name, bus.first_fail, exp_ff); end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.stim, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail} !== '0) begin
      errors++;
      $display("FAIL %s outputs got stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
               name, bus.stim, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail);
    end
    checks++;
    if ({bus2.stim, bus2.busy, bus2.done, bus2.pass, bus2.err_count} !== '0) begin
      errors++;
      $display("FAIL %s n2_outputs got stim=%0d busy=%b done=%b want all 0", name, bus2.stim, bus2.busy, bus2.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_parity();
    mode = 0;
    check_sweep("parity", 0, -1);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.stim !== 4'hF) begin
      errors++;
      $display("FAIL done_hold got done=%b pass=%b stim=%0d want 1 1 15", bus.done, bus.pass, bus.stim);
    end
  endtask

  task automatic test_stuck0();
    mode = 1;
    check_sweep("stuck0", 1, -1);
  endtask

  task automatic test_single_error();
    mode = 2;
    check_sweep("vec12", 2, -1);
  endtask

  task automatic test_sample_point();
    mode = 4;
    check_sweep("sample_point", 4, -1);
  endtask

  task automatic test_start_ignored();
    mode = 0;
    check_sweep("start_in_run", 0, 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      rand_tt = 16'($urandom);
      mode = 3;
      check_sweep($sformatf("random%0d", i), 3, -1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit seen;
    mode = 1;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (bus.stim == 4'd5) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_reset_reach stim got %0d want 5", bus.stim); end
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset_async");
    @(negedge clk);
    check_all_zero("mid_reset_held");
    rst = 1'b0;
    mode = 0;
    check_sweep("after_reset", 0, -1);
  endtask

  task automatic test_back_to_back_n2();
    int busy_cyc;
    bit ok;
    for (int s = 0; s < 2; s++) begin
      and_mode = (s == 1);
      @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      checks++;
      if (bus2.busy !== 1'b1 || bus2.done !== 1'b0 || bus2.err_count !== 3'd0 || bus2.stim !== 2'd0) begin
        errors++;
        $display("FAIL n2_start%0d got busy=%b done=%b err=%0d stim=%0d want 1 0 0 0",
                 s, bus2.busy, bus2.done, bus2.err_count, bus2.stim);
      end
      busy_cyc = 0;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (bus2.done) begin ok = 1'b1; break; end
        if (bus2.busy) busy_cyc++;
        @(negedge clk);
      end
      checks++;
      if (!ok || busy_cyc != 4) begin
        errors++;
        $display("FAIL n2_len%0d got %0d cycles done=%b want 4 done=1", s, busy_cyc, ok);
      end
      // OR vs AND differs on vectors 1 and 2
      checks++;
      if (bus2.err_count !== 3'(s == 0 ? 2 : 0) || bus2.pass !== (s == 1)) begin
        errors++;
        $display("FAIL n2_result%0d got err=%0d pass=%b want err=%0d pass=%b",
                 s, bus2.err_count, bus2.pass, s == 0 ? 2 : 0, s == 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_stuck0();
    test_single_error();
    test_sample_point();
    test_start_ignored();
    test_random();
    test_reset_mid_sweep();
    test_back_to_back_n2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive-stimulus generator and response checker for an N-input, 1-output combinational unit under test.
- Drives every input pattern 0..2^N-1 in ascending binary order and holds each pattern for HOLD clocks.
- Samples the unit's output on the last hold cycle, compares it against a parameter truth table, and reports an error count and pass/fail.
- Replaces hand-written per-vector stimulus lists for lab combinational blocks; sits beside the unit under test on the board or in simulation.

Parameters:
- N, 4, number of unit inputs (1..8).
- HOLD, 50, clocks each vector is held (>=1); output is sampled on the last of these.
- EXPECT, 16'h6996, 2^N-bit truth table; bit i = expected output for input vector i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- stim  out  N  vector driven to the unit inputs (stim[N-1] = MSB).
- dut_out  in  1  unit output under test.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  high when done=1 and err_count==0; otherwise 0.
- err_count  out  N+1  number of mismatching vectors in the current/last sweep.
- first_fail  out  N  index of the first mismatching vector (see Optional Feature).

Behaviour:
- Reset: all of the following are cleared while rst=1, independent of clk.
  - State = IDLE.
  - stim = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0.
  - Hold counter = 0.
- State machine: IDLE, RUN, DONE.
- IDLE, start=1: on the next edge go to RUN; set stim=0, hold counter=0, err_count=0, first_fail=0, busy=1, done=0.
- RUN, hold counter < HOLD-1: increment the counter; stim stays unchanged.
- RUN, hold counter == HOLD-1 (sample edge):
  - Compare dut_out with EXPECT[stim].
  - On mismatch, increment err_count.
  - If stim == 2^N-1: go to DONE with busy=0, done=1, and pass = (final err_count == 0), where final err_count includes this cycle's compare.
  - Otherwise: stim increments by 1 and the hold counter returns to 0.
- DONE: stim, err_count and first_fail hold their last values. start=1 behaves exactly as in IDLE.
- start while in RUN: ignored; no restart, no effect on counters.
- Timing:
  - Each vector is driven for exactly HOLD clocks.
  - busy is high for exactly HOLD*2^N clocks.
  - done rises on the edge after the last sample cycle.
- err_count cannot overflow, since its maximum is 2^N and it is N+1 bits wide.
- dut_out is treated as combinational from stim. The checker imposes no settle time beyond HOLD; with HOLD=1 the sample occurs in the same cycle stim is driven.
- rst asserted mid-sweep: immediate return to the reset state. No partial results are retained, and the next start begins at vector 0.
- All outputs are registered.

Optional Feature:
- Macro: VECTOR_SWEEP_FIRST_FAIL_EN.
- Defined: first_fail captures stim at the first mismatching sample of a sweep. It is written only when err_count==0 before that sample, holds its value until the next accepted start or reset, and is 0 if no mismatch occurs.
- Undefined: first_fail is tied to 0 and no capture register is built.

Test Plan:
- N=4, HOLD=3, EXPECT=16'h6996, unit = 4-input XOR parity, start pulse → stim steps 0..15, each held 3 clocks; busy high 48 clocks; then done=1, err_count=0, pass=1.
- Same config, unit stuck-at-0 → done after 48 clocks; err_count=8, pass=0; first_fail=1 with macro defined, 0 without.
- Same config, unit = parity but output inverted only for vector 12 → err_count=1, pass=0, first_fail=12 (macro defined).
- start pulsed again on clock 10 of the sweep → ignored; completion still at clock 48 and results unchanged.
- rst asserted while stim=5, released, then start → all outputs 0 during reset; new sweep begins at stim=0 and completes normally with err_count=0.
- N=2, HOLD=1, EXPECT=4'b1000, unit = AND2; then start asserted in DONE → each sweep takes 4 clocks with pass=1; the restart clears done and err_count on the accepted start.
